// File: rtl/HighLevelControl.sv
// Shared high-level control encodings used by the decode front end.
package HighLevelControl;

    typedef enum logic [2:0] {
        Imm11t0 = 3'd0,
        Imm4t0  = 3'd1,
        SType   = 3'd2,
        BType   = 3'd3,
        UType   = 3'd4,
        JType   = 3'd5
    } immSrc;

endpackage

// File: rtl/decode_skid_controller.sv
// Two-entry skid buffer between fetch and decode; pre-decodes the immediate
// format of each beat at capture so ImmSrc is registered alongside the instruction.
module decode_skid_controller #(
    parameter int unsigned BIT_COUNT = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        FetchValid,
    output logic                        FetchReady,
    input  logic [31:0]                 FetchInstr,
    input  logic [BIT_COUNT-1:0]        FetchPC,
    input  logic                        Flush,
    output logic                        DecodeValid,
    input  logic                        DecodeReady,
    output logic [31:0]                 DecodeInstr,
    output logic [BIT_COUNT-1:0]        DecodePC,
    output HighLevelControl::immSrc     ImmSrc,
    output logic                        ImmUsed,
    output logic                        IllegalInstr,
    output logic [CNT_WIDTH-1:0]        BubbleCount
);

    import HighLevelControl::*;

    localparam int unsigned INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                 fetch_xfer, decode_xfer;
    logic                 load_main_in, load_skid_in, load_main_skid;

    logic [INSTR_W-1:0]   skid_instr;
    logic [BIT_COUNT-1:0] skid_pc;
    immSrc                skid_imm_src;
    logic                 skid_imm_used;
    logic                 skid_illegal;

    immSrc                in_imm_src;
    logic                 in_imm_used;
    logic                 in_illegal;

    logic [6:0]           opcode;
    logic [2:0]           funct3;

    assign opcode      = FetchInstr[6:0];
    assign funct3      = FetchInstr[14:12];
    assign fetch_xfer  = FetchValid & FetchReady;
    assign decode_xfer = DecodeValid & DecodeReady;

    // Immediate-format pre-decode of the incoming beat
    always_comb begin
        in_imm_src  = Imm11t0;
        in_imm_used = 1'b0;
        in_illegal  = 1'b0;
        case (opcode)
            7'b0010011: begin
                in_imm_used = 1'b1;
                in_imm_src  = (funct3 == 3'b001 || funct3 == 3'b101) ? Imm4t0 : Imm11t0;
            end
            7'b0000011, 7'b1100111: in_imm_used = 1'b1;
            7'b0100011: begin
                in_imm_used = 1'b1;
                in_imm_src  = SType;
            end
            7'b0110111, 7'b0010111: begin
                in_imm_used = 1'b1;
                in_imm_src  = UType;
            end
            7'b1101111: begin
                in_imm_used = 1'b1;
                in_imm_src  = JType;
            end
            7'b1100011: begin
                in_imm_used = 1'b1;
                in_imm_src  = BType;
            end
            7'b0110011: in_imm_used = 1'b0;
            default:    in_illegal  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and entry-load strobes; Flush overrides everything
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (fetch_xfer) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (fetch_xfer && decode_xfer) begin
                    load_main_in = 1'b1;
                end else if (fetch_xfer) begin
                    load_skid_in = 1'b1;
                    state_nxt    = FULL;
                end else if (decode_xfer) begin
                    state_nxt    = EMPTY;
                end
            end
            FULL: begin
                if (decode_xfer) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (Flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_main_skid = 1'b0;
        end
    end

    // Handshake flags are registered images of the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            DecodeValid <= 1'b0;
            FetchReady  <= 1'b1;
        end else begin
            DecodeValid <= (state_nxt != EMPTY);
            FetchReady  <= (state_nxt != FULL);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            DecodeInstr  <= NOP_INSTR;
            DecodePC     <= '0;
            ImmSrc       <= Imm11t0;
            ImmUsed      <= 1'b1;
            IllegalInstr <= 1'b0;
        end else if (load_main_in) begin
            DecodeInstr  <= FetchInstr;
            DecodePC     <= FetchPC;
            ImmSrc       <= in_imm_src;
            ImmUsed      <= in_imm_used;
            IllegalInstr <= in_illegal;
        end else if (load_main_skid) begin
            DecodeInstr  <= skid_instr;
            DecodePC     <= skid_pc;
            ImmSrc       <= skid_imm_src;
            ImmUsed      <= skid_imm_used;
            IllegalInstr <= skid_illegal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_instr    <= NOP_INSTR;
            skid_pc       <= '0;
            skid_imm_src  <= Imm11t0;
            skid_imm_used <= 1'b1;
            skid_illegal  <= 1'b0;
        end else if (load_skid_in) begin
            skid_instr    <= FetchInstr;
            skid_pc       <= FetchPC;
            skid_imm_src  <= in_imm_src;
            skid_imm_used <= in_imm_used;
            skid_illegal  <= in_illegal;
        end
    end

    // Starved-cycle counter, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            BubbleCount <= '0;
        end else if (DecodeReady && !DecodeValid && !Flush && (BubbleCount != '1)) begin
            BubbleCount <= BubbleCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_decode_skid_controller.sv
// Directed bench for decode_skid_controller: handshake, ordering, flush,
// immediate pre-decode and bubble counter saturation.
module tb_decode_skid_controller;

    localparam int unsigned BW = 32;
    localparam int unsigned CW = 4;

    logic                    clk;
    logic                    reset_n;
    logic                    FetchValid;
    logic                    FetchReady;
    logic [31:0]             FetchInstr;
    logic [BW-1:0]           FetchPC;
    logic                    Flush;
    logic                    DecodeValid;
    logic                    DecodeReady;
    logic [31:0]             DecodeInstr;
    logic [BW-1:0]           DecodePC;
    HighLevelControl::immSrc ImmSrc;
    logic                    ImmUsed;
    logic                    IllegalInstr;
    logic [CW-1:0]           BubbleCount;

    int passes;
    int total;

    decode_skid_controller #(.BIT_COUNT(BW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .FetchValid   (FetchValid),
        .FetchReady   (FetchReady),
        .FetchInstr   (FetchInstr),
        .FetchPC      (FetchPC),
        .Flush        (Flush),
        .DecodeValid  (DecodeValid),
        .DecodeReady  (DecodeReady),
        .DecodeInstr  (DecodeInstr),
        .DecodePC     (DecodePC),
        .ImmSrc       (ImmSrc),
        .ImmUsed      (ImmUsed),
        .IllegalInstr (IllegalInstr),
        .BubbleCount  (BubbleCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        FetchValid = v;
        FetchInstr = ins;
        FetchPC    = pc;
    endtask

    initial begin
        passes      = 0;
        total       = 0;
        reset_n     = 1'b0;
        Flush       = 1'b0;
        DecodeReady = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        #12;
        chk("rst_valid",  64'(DecodeValid), 64'd0);
        chk("rst_ready",  64'(FetchReady), 64'd1);
        chk("rst_bubble", 64'(BubbleCount), 64'd0);
        chk("rst_instr",  64'(DecodeInstr), 64'h13);
        chk("rst_immsrc", 64'(ImmSrc), 64'(HighLevelControl::Imm11t0));
        chk("rst_immused", 64'(ImmUsed), 64'd1);
        chk("rst_illegal", 64'(IllegalInstr), 64'd0);
        step();
        reset_n = 1'b1;

        // single beat, one-cycle latency
        offer(1'b1, 32'h0050_0093, 32'h100);
        DecodeReady = 1'b1;
        step();
        chk("lat_valid",   64'(DecodeValid), 64'd1);
        chk("lat_pc",      64'(DecodePC), 64'h100);
        chk("lat_instr",   64'(DecodeInstr), 64'h0050_0093);
        chk("lat_immsrc",  64'(ImmSrc), 64'(HighLevelControl::Imm11t0));
        chk("lat_immused", 64'(ImmUsed), 64'd1);
        offer(1'b0, 32'h0, 32'h0);
        step();
        chk("drain_valid", 64'(DecodeValid), 64'd0);

        // fill both entries with decode stalled
        DecodeReady = 1'b0;
        offer(1'b1, 32'h0011_2023, 32'h200);
        step();
        offer(1'b1, 32'hFE00_0EE3, 32'h204);
        step();
        chk("full_ready",  64'(FetchReady), 64'd0);
        chk("full_valid",  64'(DecodeValid), 64'd1);
        offer(1'b1, 32'h0000_0013, 32'h208);
        step();
        chk("stall_instr", 64'(DecodeInstr), 64'h0011_2023);
        chk("stall_pc",    64'(DecodePC), 64'h200);
        chk("stall_src",   64'(ImmSrc), 64'(HighLevelControl::SType));
        offer(1'b0, 32'h0, 32'h0);
        DecodeReady = 1'b1;
        step();
        chk("ord2_instr",  64'(DecodeInstr), 64'hFE00_0EE3);
        chk("ord2_pc",     64'(DecodePC), 64'h204);
        chk("ord2_src",    64'(ImmSrc), 64'(HighLevelControl::BType));
        chk("ord2_ready",  64'(FetchReady), 64'd1);
        step();
        chk("ord_empty",   64'(DecodeValid), 64'd0);

        // back-to-back streaming through ONE with both transfers
        offer(1'b1, 32'h0000_10B7, 32'h300);
        step();
        chk("lui_src",     64'(ImmSrc), 64'(HighLevelControl::UType));
        offer(1'b1, 32'h0000_006F, 32'h304);
        step();
        chk("jal_src",     64'(ImmSrc), 64'(HighLevelControl::JType));
        chk("jal_pc",      64'(DecodePC), 64'h304);
        chk("jal_ready",   64'(FetchReady), 64'd1);
        offer(1'b1, 32'h0020_9093, 32'h308);
        step();
        chk("slli_src",    64'(ImmSrc), 64'(HighLevelControl::Imm4t0));
        offer(1'b1, 32'h0000_0000, 32'h30C);
        step();
        chk("ill_flag",    64'(IllegalInstr), 64'd1);
        chk("ill_used",    64'(ImmUsed), 64'd0);
        chk("ill_src",     64'(ImmSrc), 64'(HighLevelControl::Imm11t0));
        offer(1'b1, 32'h0020_81B3, 32'h310);
        step();
        chk("add_flag",    64'(IllegalInstr), 64'd0);
        chk("add_used",    64'(ImmUsed), 64'd0);
        chk("add_src",     64'(ImmSrc), 64'(HighLevelControl::Imm11t0));
        offer(1'b0, 32'h0, 32'h0);
        step();
        chk("stream_empty", 64'(DecodeValid), 64'd0);

        // flush from FULL drops held and offered beats
        DecodeReady = 1'b0;
        offer(1'b1, 32'h0011_2023, 32'h400);
        step();
        offer(1'b1, 32'hFE00_0EE3, 32'h404);
        step();
        chk("pre_flush_ready", 64'(FetchReady), 64'd0);
        Flush = 1'b1;
        offer(1'b1, 32'h0000_10B7, 32'h408);
        step();
        chk("flush_valid", 64'(DecodeValid), 64'd0);
        chk("flush_ready", 64'(FetchReady), 64'd1);
        Flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        DecodeReady = 1'b1;
        step();
        step();
        chk("flush_no_stale", 64'(DecodeValid), 64'd0);
        offer(1'b1, 32'h0000_006F, 32'h500);
        step();
        chk("post_flush_pc", 64'(DecodePC), 64'h500);
        chk("post_flush_valid", 64'(DecodeValid), 64'd1);
        offer(1'b0, 32'h0, 32'h0);
        step();

        // bubble counter counts and saturates
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        DecodeReady = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("bubble_3", 64'(BubbleCount), 64'd3);
        for (int i = 0; i < 17; i++) step();
        chk("bubble_sat", 64'(BubbleCount), 64'd15);
        offer(1'b1, 32'h0050_0093, 32'h600);
        step();
        chk("bubble_hold", 64'(BubbleCount), 64'd15);
        chk("pre_rst_valid", 64'(DecodeValid), 64'd1);
        offer(1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("async_bubble", 64'(BubbleCount), 64'd0);
        chk("async_valid",  64'(DecodeValid), 64'd0);
        chk("async_ready",  64'(FetchReady), 64'd1);
        chk("async_instr",  64'(DecodeInstr), 64'h13);
        step();
        reset_n = 1'b1;
        step();
        chk("after_rst_valid", 64'(DecodeValid), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
